apb_master_bridge: RTL and testbench

- APB initiator: converts single-beat commands from a local valid/ready port into APB3/APB4 SETUP/ACCESS transfers and returns one response per command.
- Drives the same PADDR/PWRITE/PWDATA/PSTRB/PSEL/PENABLE bus that the bus monitor observes. Samples PRDATA/PREADY/PSLVERR from the selected completer.
- One outstanding transfer at a time.

---
 rtl/apb_master_bridge.sv | 128 ++++++++++++
 tb/tb_apb_master_bridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3/APB4 initiator: one valid/ready command in, one SETUP/ACCESS transfer out, one response pulse back.
// Optional wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_q;
`endif

  assign cmd_ready = (state_q == IDLE) && !PRESET;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            // Reads keep the previous write data on the bus and drive no strobes.
            if (cmd_write) begin
              pwdata_q <= cmd_wdata;
              pstrb_q  <= cmd_strb;
            end else begin
              pstrb_q  <= '0;
            end
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q  <= 1'b1;
          state_q    <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt_q == CW'(TIMEOUT_CYCLES)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= IDLE;
          end else begin
            wait_cnt_q  <= wait_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: latency, wait states, errors, back-to-back, reset abort
// and (with APB_TIMEOUT_EN) the wait-state timeout.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Checks the full APB bus in one go: {PSEL,PENABLE,PWRITE,PSTRB,PADDR}, then PWDATA.
  task automatic chk_bus(input string tag, input logic sel, input logic en, input logic wr,
                         input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wdata);
    chk({tag, ".ctl"}, {57'd0, PSEL, PENABLE, PWRITE, PSTRB}, {57'd0, sel, en, wr, strb});
    chk({tag, ".addr"}, {32'd0, PADDR}, {32'd0, addr});
    chk({tag, ".wdata"}, {32'd0, PWDATA}, {32'd0, wdata});
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    step(); step();
    chk("rst.cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk_bus("rst.bus", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst.rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    PRESET = 1'b0;
    #1;
    chk("idle.cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // 1: zero-wait write
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    step(); cmd_valid = 1'b0;
    chk_bus("wr.setup", 1'b1, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    chk("wr.setup.busy", {62'd0, cmd_ready, rsp_valid}, 64'd0);
    step();
    chk_bus("wr.access", 1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    step();
    chk("wr.rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b0, 32'h0});
    chk("wr.rsp.ready", {62'd0, cmd_ready, PSEL}, {62'd0, 1'b1, 1'b0});
    chk_bus("wr.idle.hold", 1'b0, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    step();
    chk("wr.pulse1", {63'd0, rsp_valid}, 64'd0);

    // 2: read with two wait states; PRDATA/PSLVERR garbage before ACCESS must be ignored
    PREADY = 1'b0; PRDATA = 32'hFFFF_0000; PSLVERR = 1'b1;
    issue(1'b0, 32'h0000_0020, 32'h5555_5555, 4'h3);
    step(); cmd_valid = 1'b0;
    chk_bus("rd.setup", 1'b1, 1'b0, 1'b0, 4'h0, 32'h20, 32'hDEAD_BEEF);
    step(); PSLVERR = 1'b0; PRDATA = 32'h1234_5678;
    chk_bus("rd.acc1", 1'b1, 1'b1, 1'b0, 4'h0, 32'h20, 32'hDEAD_BEEF);
    step();
    chk_bus("rd.acc2", 1'b1, 1'b1, 1'b0, 4'h0, 32'h20, 32'hDEAD_BEEF);
    chk("rd.acc2.norsp", {63'd0, rsp_valid}, 64'd0);
    step(); PREADY = 1'b1;
    chk_bus("rd.acc3", 1'b1, 1'b1, 1'b0, 4'h0, 32'h20, 32'hDEAD_BEEF);
    step();
    chk("rd.rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b0, 32'h1234_5678});
    step();

    // 3: write slave error, then a clean read
    PSLVERR = 1'b1;
    issue(1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'h5);
    step(); cmd_valid = 1'b0;
    step(); step();
    chk("err.rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b1, 32'h0});
    PSLVERR = 1'b0; PRDATA = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_0034, 32'h0, 4'hF);
    step(); cmd_valid = 1'b0;
    step(); step();
    chk("ok.rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b0, 32'hCAFE_0001});
    step();

    // 4: back-to-back commands held by the requester
    issue(1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF);
    step();
    issue(1'b1, 32'h0000_0200, 32'h2222_2222, 4'hC);
    chk("b2b.busy1", {63'd0, cmd_ready}, 64'd0);
    chk_bus("b2b.a.setup", 1'b1, 1'b0, 1'b1, 4'hF, 32'h100, 32'h1111_1111);
    step();
    chk_bus("b2b.a.access", 1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'h1111_1111);
    step();
    chk("b2b.a.rsp", {62'd0, rsp_valid, cmd_ready}, {62'd0, 1'b1, 1'b1});
    step(); cmd_valid = 1'b0;
    chk_bus("b2b.b.setup", 1'b1, 1'b0, 1'b1, 4'hC, 32'h200, 32'h2222_2222);
    chk("b2b.b.norsp", {63'd0, rsp_valid}, 64'd0);
    step();
    chk_bus("b2b.b.access", 1'b1, 1'b1, 1'b1, 4'hC, 32'h200, 32'h2222_2222);
    step();
    chk("b2b.b.rsp", {63'd0, rsp_valid}, 64'd1);
    step();

    // 5: reset in the middle of ACCESS
    PREADY = 1'b0;
    issue(1'b1, 32'h0000_0300, 32'h3333_3333, 4'hF);
    step(); cmd_valid = 1'b0;
    step();
    chk("rst.mid.pre", {62'd0, PSEL, PENABLE}, {62'd0, 2'b11});
    PRESET = 1'b1;
    #1;
    chk_bus("rst.mid.bus", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst.mid.ready", {62'd0, cmd_ready, rsp_valid}, 64'd0);
    PREADY = 1'b1;
    step();
    PRESET = 1'b0;
    step();
    chk("rst.mid.norsp", {62'd0, rsp_valid, PSEL}, 64'd0);
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    PRDATA = 32'h0BAD_F00D;
    step(); cmd_valid = 1'b0;
    chk_bus("post.setup", 1'b1, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0);
    step(); step();
    chk("post.rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b0, 32'h0BAD_F00D});
    step();

`ifdef APB_TIMEOUT_EN
    // 6: completer never ready; limit of 4 wait cycles then abort
    PREADY = 1'b0; PRDATA = 32'h7777_7777;
    issue(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    step(); cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("to.access", {61'd0, PSEL, PENABLE, rsp_valid}, {61'd0, 3'b110});
      step();
    end
    chk("to.rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, {30'd0, 1'b1, 1'b1, 32'h0});
    chk("to.ready", {61'd0, cmd_ready, PSEL, PENABLE}, {61'd0, 3'b100});
    PREADY = 1'b1;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
